// File: rtl/srl_iter_unit.sv
// Iterative right shifter: one bit position per clock, start/done handshake.
// Define SRL_ITER_ARITH_EN to honour the arith input (sign fill); otherwise all shifts are logical.
module srl_iter_unit #(
  parameter int N   = 32,
  parameter int SHW = 5
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   din,
  input  logic [SHW-1:0] shamt,
  input  logic           arith,
  output logic           busy,
  output logic           done,
  output logic [N-1:0]   dout
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [SHW-1:0] cnt_q, cnt_d;
  logic [N-1:0]   work_q, work_d;
  logic           fill;
  logic           accept;

`ifdef SRL_ITER_ARITH_EN
  logic fill_q, fill_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) fill_q <= 1'b0;
    else       fill_q <= fill_d;
  end

  always_comb begin
    fill_d = fill_q;
    if (accept) fill_d = arith & din[N-1];
  end

  assign fill = fill_q;
`else
  logic unused_arith;
  assign unused_arith = arith;
  assign fill         = 1'b0;
`endif

  assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      S_SHIFT: begin
        work_d = {fill, work_q[N-1:1]};
        cnt_d  = cnt_q - SHW'(1);
        if (cnt_q == SHW'(1)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      S_IDLE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A new operation may also be accepted in the DONE cycle (back-to-back).
    if (accept) begin
      work_d  = din;
      cnt_d   = shamt;
      state_d = (shamt == '0) ? S_DONE : S_SHIFT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign busy = (state_q == S_SHIFT);
  assign done = (state_q == S_DONE);
  assign dout = work_q;

endmodule

// File: tb/tb_srl_iter_unit.sv
// Directed self-checking bench for srl_iter_unit (expectations follow SRL_ITER_ARITH_EN).
module tb_srl_iter_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] din;
  logic [4:0]  shamt;
  logic        arith;
  logic        busy;
  logic        done;
  logic [31:0] dout;

  int checks = 0;
  int errors = 0;
  int lat;
  int nbusy;
  int ndone;

  srl_iter_unit #(.N(32), .SHW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .din   (din),
    .shamt (shamt),
    .arith (arith),
    .busy  (busy),
    .done  (done),
    .dout  (dout)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic startop(input logic [31:0] d, input logic [4:0] s, input logic a);
    start = 1'b1;
    din   = d;
    shamt = s;
    arith = a;
    step();
    start = 1'b0;
    din   = 32'h5A5A_A5A5;
    shamt = 5'd17;
    arith = ~a;
  endtask

  // Cycle index 1 is the cycle right after the current position; lat=0 means no done seen.
  task automatic run_wait(output int l, output int b);
    l = 0;
    b = 0;
    for (int i = 1; i <= 40; i++) begin
      if (done) begin
        l = i;
        break;
      end
      if (busy) b++;
      step();
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    din   = '0;
    shamt = '0;
    arith = 1'b0;
    #7;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dout", dout, 32'h0);
    #5 reset = 1'b0;
    step();

    // Reset mid-shift
    startop(32'hFFFF_0000, 5'd20, 1'b0);
    chk("mid_busy_before", 32'(busy), 32'd1);
    repeat (4) step();
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_dout", dout, 32'h0);
    #2 reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (done) ndone++;
    end
    chk("mid_no_done", 32'(ndone), 32'd0);
    chk("mid_idle_busy", 32'(busy), 32'd0);

    // Logical shift
    startop(32'h8000_00F0, 5'd4, 1'b0);
    run_wait(lat, nbusy);
    chk("lsr_lat", 32'(lat), 32'd5);
    chk("lsr_busy", 32'(nbusy), 32'd4);
    chk("lsr_dout", dout, 32'h0800_000F);
    step();
    chk("lsr_done_pulse", 32'(done), 32'd0);
    chk("lsr_hold", dout, 32'h0800_000F);
    step();

    // Arithmetic request
    startop(32'h8000_00F0, 5'd4, 1'b1);
    run_wait(lat, nbusy);
    chk("asr_lat", 32'(lat), 32'd5);
`ifdef SRL_ITER_ARITH_EN
    chk("asr_dout", dout, 32'hF800_000F);
`else
    chk("asr_dout", dout, 32'h0800_000F);
`endif
    step();

    // shamt = 0
    startop(32'h1234_5678, 5'd0, 1'b0);
    run_wait(lat, nbusy);
    chk("z_lat", 32'(lat), 32'd1);
    chk("z_busy", 32'(nbusy), 32'd0);
    chk("z_dout", dout, 32'h1234_5678);
    step();

    // shamt = 31, negative operand
    startop(32'h8000_0000, 5'd31, 1'b1);
    run_wait(lat, nbusy);
    chk("max_lat", 32'(lat), 32'd32);
    chk("max_busy", 32'(nbusy), 32'd31);
`ifdef SRL_ITER_ARITH_EN
    chk("max_dout", dout, 32'hFFFF_FFFF);
`else
    chk("max_dout", dout, 32'h0000_0001);
`endif
    step();

    // start during SHIFT is ignored
    startop(32'h0000_0100, 5'd8, 1'b0);
    step();
    step();
    start = 1'b1;
    din   = 32'hDEAD_BEEF;
    shamt = 5'd3;
    step();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    run_wait(lat, nbusy);
    chk("ign_lat", 32'(lat), 32'd6);
    chk("ign_dout", dout, 32'h0000_0001);
    step();
    chk("ign_no_second", 32'(done), 32'd0);
    step();

    // Back-to-back: new start accepted in the DONE cycle
    startop(32'h0000_0100, 5'd8, 1'b0);
    run_wait(lat, nbusy);
    chk("b2b_first_lat", 32'(lat), 32'd9);
    chk("b2b_first_dout", dout, 32'h0000_0001);
    startop(32'h0000_0010, 5'd4, 1'b0);
    chk("b2b_pulse_one", 32'(done), 32'd0);
    chk("b2b_busy", 32'(busy), 32'd1);
    run_wait(lat, nbusy);
    chk("b2b_second_lat", 32'(lat), 32'd5);
    chk("b2b_second_dout", dout, 32'h0000_0001);
    step();
    chk("b2b_end_done", 32'(done), 32'd0);
    chk("b2b_hold", dout, 32'h0000_0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srl_iter_unit.md
Name: srl_iter_unit

Overview:
- Iterative right-shift unit for the MIPS datapath: executes srl/sra (and srlv/srav via register shamt) one bit position per clock.
- It is the right-shift counterpart of the existing fixed left-shift-by-2 path.
- It sits beside the ALU and is started by the controller with a start/done handshake.
- Its result is muxed into the writeback path when done pulses.

Parameters:
- N, 32, data width in bits.
- SHW, 5, shift-amount width; must equal clog2(N).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only when the unit can accept (IDLE or DONE state).
- din  input  N  operand to shift (instruction rt value).
- shamt  input  SHW  shift amount, 0..N-1.
- arith  input  1  1 = arithmetic (sign fill), 0 = logical (zero fill).
- busy  output  1  high while in SHIFT state.
- done  output  1  one-cycle pulse; dout is valid from this cycle on.
- dout  output  N  shift result; held stable until the next accepted start.

Behaviour:
- States: IDLE, SHIFT, DONE. Encoding is free.
- Reset (async, any time, including mid-shift):
  - state=IDLE, busy=0, done=0, dout=0.
  - Internal count=0, fill bit=0.
- Accept condition: start=1 at a rising edge while state is IDLE or DONE.
- On accept:
  - The working register loads din; dout tracks the working register.
  - count loads shamt.
  - The fill bit captures arith & din[N-1].
- Next state after accept: shamt==0 goes to DONE; otherwise goes to SHIFT.
- Each SHIFT edge:
  - Working register becomes {fill, reg[N-1:1]}.
  - count decrements by 1.
  - When count reaches 0 on this edge, go to DONE.
- DONE lasts exactly one cycle with done=1, then returns to IDLE unless a new start is accepted in that same cycle. Back-to-back operation is allowed; done still pulses only one cycle per operation.
- Latency: done is high in the cycle after the (shamt+1)-th rising edge counted from the accepting edge.
  - shamt=0 gives 1 cycle.
  - shamt=31 gives 32 cycles.
- busy=1 exactly during SHIFT cycles (shamt cycles per operation); busy=0 in IDLE and DONE.
- start during SHIFT is ignored. No queuing, no error flag.
- din, shamt and arith are sampled only at the accepting edge; later changes have no effect on the operation in flight.
- dout is undefined-by-contract while busy=1 (it shows intermediate values). Consumers use it only when done=1 or afterwards in IDLE.
- Result equals din >> shamt (logical) or $signed(din) >>> shamt (arithmetic), truncated to N bits.
- Shifting a negative value arithmetically by N-1 yields all ones.
- No combinational path from inputs to outputs; all outputs are registered.

Optional Feature:
- Macro: SRL_ITER_ARITH_EN.
- Defined: arith port is functional as described above (sra/srav supported).
- Undefined:
  - The arith port remains in the port list but is ignored.
  - The fill bit is always 0; all shifts are logical.
  - No sign-capture logic is synthesized.

Test Plan:
- Reset mid-shift: start din=32'hFFFF_0000, shamt=20, arith=0; assert reset after 5 cycles.
  -> Immediately busy=0, done=0, dout=0. After release, state is IDLE (no done pulse appears).
- Logical shift: din=32'h8000_00F0, shamt=4, arith=0.
  -> busy high 4 cycles; done pulses 5 cycles after start; dout=32'h0800_000F, held afterwards.
- Arithmetic shift (macro defined): din=32'h8000_00F0, shamt=4, arith=1.
  -> dout=32'hF800_000F.
  -> Same stimulus with macro undefined -> dout=32'h0800_000F.
- Boundaries:
  - shamt=0, din=32'h1234_5678 -> done 1 cycle after start, busy never high, dout=32'h1234_5678.
  - shamt=31, din=32'h8000_0000, arith=1 -> dout=32'hFFFF_FFFF after 32 cycles.
- Ignored start and back-to-back:
  - Pulse start with din=32'hDEAD_BEEF during SHIFT of din=32'h0000_0100, shamt=8 -> result 32'h0000_0001 is unaffected.
  - start asserted in the DONE cycle with din=32'h0000_0010, shamt=4 -> accepted; second done pulses with dout=32'h0000_0001.
